reg_file_param: RTL and testbench

- Parametrised successor to the 8x8 CPU register file.
- Provides DEPTH = 2**ADDR_W entries of DATA_W bits, two asynchronous read ports and one clocked write port.
- Adds a one-entry deferred-write buffer so writes issued during BUSYWAIT commit later instead of being lost, with optional read bypass from that buffer.
- Adds an optional hard-wired zero register and an optional sequential (one entry per cycle) reset-clear engine.
- Sits in the CPU datapath between the ALU/data-memory write-back mux and the ALU operand inputs.

---
 rtl/reg_file_param_if.sv | 28 ++
 rtl/reg_file_param.sv | 116 +++++++++++
 tb/tb_reg_file_param.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_param_if.sv
// Register-file access bus: write port, two read ports, stall input and status flags.
interface reg_file_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic signed [DATA_W-1:0] IN;
  logic        [ADDR_W-1:0] INADDRESS;
  logic        [ADDR_W-1:0] OUT1ADDRESS;
  logic        [ADDR_W-1:0] OUT2ADDRESS;
  logic                     WRITE;
  logic                     BUSYWAIT;
  logic signed [DATA_W-1:0] OUT1;
  logic signed [DATA_W-1:0] OUT2;
  logic                     PENDING;
  logic                     CLEAR_BUSY;

  // Datapath side driving writes and read addresses
  modport master (
    output IN, INADDRESS, OUT1ADDRESS, OUT2ADDRESS, WRITE, BUSYWAIT,
    input  OUT1, OUT2, PENDING, CLEAR_BUSY
  );

  // Register file itself
  modport slave (
    input  IN, INADDRESS, OUT1ADDRESS, OUT2ADDRESS, WRITE, BUSYWAIT,
    output OUT1, OUT2, PENDING, CLEAR_BUSY
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised CPU register file: two combinational read ports, one clocked write
// port, a one-entry deferred-write buffer for writes issued under BUSYWAIT, an
// optional zero register and an optional one-entry-per-cycle clear after RESET.
// READ_DELAY/WRITE_DELAY describe the behavioural timing of the original model;
// the synthesizable datapath here is zero-delay.
module reg_file_param #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int          READ_DELAY  = 2,
  parameter int          WRITE_DELAY = 1,
  parameter int unsigned BYPASS      = 1,
  parameter int unsigned ZERO_REG0   = 0,
  parameter int unsigned CLEAR_MODE  = 0
) (
  input logic             CLK,
  input logic             RESET,
  reg_file_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  if ((READ_DELAY < 0) || (WRITE_DELAY < 0) || (BYPASS > 1) || (ZERO_REG0 > 1) ||
      (CLEAR_MODE > 1)) begin : g_param_check
    $error("reg_file_param: illegal parameter value");
  end

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic                     pend_q;
  logic        [ADDR_W-1:0] buf_addr_q;
  logic signed [DATA_W-1:0] buf_data_q;
  state_e                   state_q;
  logic        [ADDR_W-1:0] idx_q;

  logic                     clear_busy;
  logic                     wr_zero;
  logic                     buf_zero;
  logic signed [DATA_W-1:0] out1;
  logic signed [DATA_W-1:0] out2;

  assign clear_busy = (CLEAR_MODE != 0) && (state_q == StClear);
  // Accesses to entry 0 are discarded when it is hard-wired to zero
  assign wr_zero    = (ZERO_REG0 != 0) && (bus.INADDRESS == '0);
  assign buf_zero   = (ZERO_REG0 != 0) && (buf_addr_q == '0);

  // Reset/clear engine, deferred-write buffer and array commits
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q     <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      if (CLEAR_MODE == 0) begin
        mem_q   <= '{default: '0};
        state_q <= StIdle;
        idx_q   <= '0;
      end else begin
        mem_q[0] <= '0;
        state_q  <= StClear;
        idx_q    <= ADDR_W'(1);
      end
    end else if (clear_busy) begin
      // Writes are neither accepted nor buffered while clearing
      pend_q       <= 1'b0;
      mem_q[idx_q] <= '0;
      idx_q        <= idx_q + 1'b1;
      if (idx_q == ADDR_W'(DEPTH - 1)) begin
        state_q <= StIdle;
      end
    end else if (bus.BUSYWAIT) begin
      // Newest deferred write replaces any older pending one
      if (bus.WRITE && !wr_zero) begin
        pend_q     <= 1'b1;
        buf_addr_q <= bus.INADDRESS;
        buf_data_q <= bus.IN;
      end
    end else begin
      if (pend_q && !buf_zero) begin
        mem_q[buf_addr_q] <= buf_data_q;
      end
      // Issued after the buffer commit so the new write wins on an address clash
      if (bus.WRITE && !wr_zero) begin
        mem_q[bus.INADDRESS] <= bus.IN;
      end
      pend_q <= 1'b0;
    end
  end

  // Read port 1: clear blanking, zero register, buffer bypass, then array
  always_comb begin
    out1 = mem_q[bus.OUT1ADDRESS];
    if (clear_busy) begin
      out1 = '0;
    end else if ((ZERO_REG0 != 0) && (bus.OUT1ADDRESS == '0)) begin
      out1 = '0;
    end else if ((BYPASS != 0) && pend_q && (bus.OUT1ADDRESS == buf_addr_q)) begin
      out1 = buf_data_q;
    end
  end

  // Read port 2: same selection as port 1
  always_comb begin
    out2 = mem_q[bus.OUT2ADDRESS];
    if (clear_busy) begin
      out2 = '0;
    end else if ((ZERO_REG0 != 0) && (bus.OUT2ADDRESS == '0)) begin
      out2 = '0;
    end else if ((BYPASS != 0) && pend_q && (bus.OUT2ADDRESS == buf_addr_q)) begin
      out2 = buf_data_q;
    end
  end

  assign bus.OUT1       = out1;
  assign bus.OUT2       = out2;
  assign bus.PENDING    = pend_q;
  assign bus.CLEAR_BUSY = clear_busy;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: four instances sharing one stimulus bus
// (0: defaults, 1: BYPASS=0, 2: CLEAR_MODE=1, 3: ZERO_REG0=1), each with its own RESET.
module tb_reg_file_param;
  logic       clk = 1'b0;
  logic [3:0] rst;
  logic [7:0] in_s;
  logic [2:0] wa_s, ra1_s, ra2_s;
  logic       wr_s, bw_s;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_W(8), .ADDR_W(3)) ifs [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign ifs[g].IN          = in_s;
    assign ifs[g].INADDRESS   = wa_s;
    assign ifs[g].OUT1ADDRESS = ra1_s;
    assign ifs[g].OUT2ADDRESS = ra2_s;
    assign ifs[g].WRITE       = wr_s;
    assign ifs[g].BUSYWAIT    = bw_s;
  end

  reg_file_param #(.BYPASS(1), .ZERO_REG0(0), .CLEAR_MODE(0)) u_def (
    .CLK(clk), .RESET(rst[0]), .bus(ifs[0]));
  reg_file_param #(.BYPASS(0), .ZERO_REG0(0), .CLEAR_MODE(0)) u_nobyp (
    .CLK(clk), .RESET(rst[1]), .bus(ifs[1]));
  reg_file_param #(.BYPASS(1), .ZERO_REG0(0), .CLEAR_MODE(1)) u_clr (
    .CLK(clk), .RESET(rst[2]), .bus(ifs[2]));
  reg_file_param #(.BYPASS(1), .ZERO_REG0(1), .CLEAR_MODE(0)) u_zero (
    .CLK(clk), .RESET(rst[3]), .bus(ifs[3]));

  typedef struct {
    logic       rst, wr, bw;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra1, ra2;
    logic [7:0] e1, e2;
    logic       ep;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input int r, input int w, input int b, input int a,
                              input int d, input int r1, input int r2, input int x1,
                              input int x2, input int p);
    vec_t v;
    v.rst = r[0];   v.wr = w[0];   v.bw = b[0];
    v.wa  = 3'(a);  v.wd = 8'(d);
    v.ra1 = 3'(r1); v.ra2 = 3'(r2);
    v.e1  = 8'(x1); v.e2 = 8'(x2);
    v.ep  = p[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic drive(input logic w, input logic b, input logic [2:0] a, input logic [7:0] d);
    wr_s = w; bw_s = b; wa_s = a; in_s = d;
  endtask

  initial begin
    int busy_cycles;
    // rst, wr, bw, wa, wd, ra1, ra2, exp1, exp2, exp_pending  (default instance)
    vecs[0]  = mk(1, 0, 0, 0,   0, 3, 6,   0,   0, 0);
    vecs[1]  = mk(0, 1, 0, 3, -23, 3, 6, -23,   0, 0);
    vecs[2]  = mk(0, 1, 0, 6,  35, 3, 6, -23,  35, 0);
    vecs[3]  = mk(0, 0, 0, 0,   0, 0, 7,   0,   0, 0);
    vecs[4]  = mk(0, 0, 0, 0,   0, 1, 2,   0,   0, 0);
    vecs[5]  = mk(0, 0, 0, 0,   0, 4, 5,   0,   0, 0);
    vecs[6]  = mk(0, 1, 1, 2,  20, 2, 3,  20, -23, 1);
    vecs[7]  = mk(0, 0, 0, 0,   0, 2, 6,  20,  35, 0);
    vecs[8]  = mk(0, 1, 0, 2,   0, 2, 6,   0,  35, 0);
    vecs[9]  = mk(0, 1, 1, 2,  20, 2, 5,  20,   0, 1);
    vecs[10] = mk(0, 1, 0, 2,  45, 2, 5,  45,   0, 0);
    vecs[11] = mk(0, 1, 1, 2,  20, 2, 5,  20,   0, 1);
    vecs[12] = mk(0, 1, 0, 5,  45, 2, 5,  20,  45, 0);
    vecs[13] = mk(0, 1, 1, 4,   7, 4, 5,   7,  45, 1);
    vecs[14] = mk(0, 0, 1, 4,  99, 4, 5,   7,  45, 1);
    vecs[15] = mk(0, 1, 1, 1,  -1, 4, 1,   0,  -1, 1);
    vecs[16] = mk(0, 0, 0, 0,   0, 4, 1,   0,  -1, 0);
    vecs[17] = mk(0, 1, 1, 6,  66, 6, 3,  66, -23, 1);
    vecs[18] = mk(1, 1, 1, 3,  50, 6, 3,   0,   0, 0);
    vecs[19] = mk(0, 0, 0, 0,   0, 6, 3,   0,   0, 0);

    rst = 4'hF;
    drive(1'b0, 1'b0, 3'd0, 8'd0);
    ra1_s = 3'd0; ra2_s = 3'd0;
    tick();
    tick();

    // Default instance; the others stay in reset meanwhile
    for (int i = 0; i < 20; i++) begin
      rst[0] = vecs[i].rst;
      drive(vecs[i].wr, vecs[i].bw, vecs[i].wa, vecs[i].wd);
      ra1_s = vecs[i].ra1; ra2_s = vecs[i].ra2;
      tick();
      check($sformatf("vec%0d out1", i), ifs[0].OUT1, vecs[i].e1);
      check($sformatf("vec%0d out2", i), ifs[0].OUT2, vecs[i].e2);
      check($sformatf("vec%0d pending", i), 8'(ifs[0].PENDING), 8'(vecs[i].ep));
    end

    // Release the others; the clear engine needs 7 more edges to finish
    drive(1'b0, 1'b0, 3'd0, 8'd0);
    rst[3:1] = 3'b000;
    tick();
    check("clr release busy", 8'(ifs[2].CLEAR_BUSY), 8'd1);
    repeat (6) tick();
    check("clr release idle", 8'(ifs[2].CLEAR_BUSY), 8'd0);
    check("def clear_busy tied", 8'(ifs[0].CLEAR_BUSY), 8'd0);

    // No bypass: the buffered write is invisible until it commits
    drive(1'b1, 1'b1, 3'd4, 8'd9);
    ra1_s = 3'd4;
    tick();
    check("nobyp buffered out1", ifs[1].OUT1, 8'd0);
    check("nobyp pending", 8'(ifs[1].PENDING), 8'd1);
    drive(1'b0, 1'b0, 3'd0, 8'd0);
    tick();
    check("nobyp committed out1", ifs[1].OUT1, 8'd9);
    check("nobyp pending clr", 8'(ifs[1].PENDING), 8'd0);

    // Zero register
    drive(1'b1, 1'b0, 3'd0, 8'd5);
    ra1_s = 3'd0;
    tick();
    check("zero write0 out1", ifs[3].OUT1, 8'd0);
    drive(1'b1, 1'b1, 3'd2, 8'd6);
    ra2_s = 3'd2;
    tick();
    check("zero buf2 pending", 8'(ifs[3].PENDING), 8'd1);
    drive(1'b1, 1'b1, 3'd0, 8'd5);
    tick();
    check("zero buf0 pending kept", 8'(ifs[3].PENDING), 8'd1);
    check("zero buf0 bypass kept", ifs[3].OUT2, 8'd6);
    drive(1'b0, 1'b0, 3'd0, 8'd0);
    tick();
    check("zero commit out1", ifs[3].OUT1, 8'd0);
    check("zero commit out2", ifs[3].OUT2, 8'd6);
    check("zero commit pending", 8'(ifs[3].PENDING), 8'd0);
    drive(1'b1, 1'b0, 3'd1, 8'd3);
    ra1_s = 3'd1;
    tick();
    check("zero write1", ifs[3].OUT1, 8'd3);
    rst[3] = 1'b1;
    drive(1'b1, 1'b0, 3'd1, 8'd8);
    tick();
    rst[3] = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 8'd0);
    check("zero reset+write1", ifs[3].OUT1, 8'd0);
    tick();
    check("zero after reset1", ifs[3].OUT1, 8'd0);

    // Sequential clear: fill with 0x11, then one RESET cycle
    for (int a = 0; a < 8; a++) begin
      drive(1'b1, 1'b0, 3'(a), 8'h11);
      tick();
    end
    drive(1'b0, 1'b0, 3'd0, 8'd0);
    ra1_s = 3'd7; ra2_s = 3'd0;
    tick();
    check("clr fill out1", ifs[2].OUT1, 8'h11);
    check("clr fill out2", ifs[2].OUT2, 8'h11);
    rst[2] = 1'b1;
    busy_cycles = 1;
    tick();
    rst[2] = 1'b0;
    check("clr e0 busy", 8'(ifs[2].CLEAR_BUSY), 8'd1);
    check("clr e0 out1", ifs[2].OUT1, 8'd0);
    if (ifs[2].CLEAR_BUSY) busy_cycles++;
    for (int k = 1; k < 8; k++) begin
      if (k == 3) drive(1'b1, 1'b0, 3'd7, 8'd12);
      else drive(1'b0, 1'b0, 3'd0, 8'd0);
      ra2_s = 3'(k);
      tick();
      if (k < 7) begin
        check($sformatf("clr e%0d busy", k), 8'(ifs[2].CLEAR_BUSY), 8'd1);
        check($sformatf("clr e%0d out1", k), ifs[2].OUT1, 8'd0);
        check($sformatf("clr e%0d out2", k), ifs[2].OUT2, 8'd0);
      end
      if (ifs[2].CLEAR_BUSY) busy_cycles++;
    end
    check("clr idle after window", 8'(ifs[2].CLEAR_BUSY), 8'd0);
    check("clr window length", 8'(busy_cycles), 8'd8);
    for (int a = 0; a < 8; a++) begin
      ra1_s = 3'(a); ra2_s = 3'(7 - a);
      #2;
      check($sformatf("clr final %0d", a), ifs[2].OUT1, 8'd0);
      check($sformatf("clr final %0d", 7 - a), ifs[2].OUT2, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
